t_toggle_arbiter: RTL

- Shared bank of NBITS T-flip-flop state bits, toggled on request by NREQ independent requesters.
- Round-robin arbiter grants at most one toggle per cycle. The winner's target bit is inverted at the next clock edge.
- Serves as the sequencing/sharing front end for T-FF-based status/parity flags in the misc block set.

---
 rtl/t_toggle_arbiter_pkg.sv | 16 +
 rtl/t_toggle_arbiter_if.sv | 30 +++
 rtl/t_toggle_arbiter_rr_arbiter.sv | 41 ++++
 rtl/t_toggle_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/t_toggle_arbiter_pkg.sv
// t_toggle_arbiter shared package: default sizes, safe clog2,
// and the packed per-requester index array type for the default build.
package tta_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int NBITS_DEF = 8;

  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDXW_DEF = clog2_safe(NBITS_DEF);

  typedef logic [NREQ_DEF-1:0][IDXW_DEF-1:0] idx_arr_t;

endpackage

// File: rtl/t_toggle_arbiter_if.sv
// Requester-side bus of t_toggle_arbiter.
// master: hold, req_valid, req_idx out; req_ready, q, grant_valid, grant_id in.
interface t_toggle_arbiter_if
  import tta_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBITS = NBITS_DEF
);
  localparam int IDXW = clog2_safe(NBITS);
  localparam int IDW  = clog2_safe(NREQ);

  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [NBITS-1:0]     q;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;

  modport master (
    output hold, req_valid, req_idx,
    input  req_ready, q, grant_valid, grant_id
  );

  modport slave (
    input  hold, req_valid, req_idx,
    output req_ready, q, grant_valid, grant_id
  );

endinterface

// File: rtl/t_toggle_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first req at or after ptr wins.
// Ports: req, ptr in; one-hot gnt and its index gnt_id out.
module rr_arbiter
  import tta_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = clog2_safe(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  function automatic logic [IDW-1:0] wrap(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan farthest offset first so the nearest requester overwrites.
  always_comb begin
    logic [IDW-1:0] sel;
    gnt    = '0;
    gnt_id = '0;
    sel    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = wrap(ptr, k);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/t_toggle_arbiter.sv
// Shared T-FF bank toggled by NREQ requesters, one grant per cycle.
// Ports: clk, rst (sync, high), bus (slave). TTA_FIXED_PRIO_EN: fixed prio.
module t_toggle_arbiter
  import tta_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NBITS = NBITS_DEF
) (
  input logic               clk,
  input logic               rst,
  t_toggle_arbiter_if.slave bus
);
  localparam int IDXW = clog2_safe(NBITS);
  localparam int IDW  = clog2_safe(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   ptr;
  logic             xfer;
  logic [IDXW-1:0]  tidx;
  logic [NBITS-1:0] q_r;
  logic             gv_r;
  logic [IDW-1:0]   gid_r;

  assign req = bus.req_valid & {NREQ{~(rst | bus.hold)}};

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (win)
  );

  assign xfer = |gnt;

  always_comb begin
    tidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) tidx = bus.req_idx[i*IDXW +: IDXW];
    end
  end

`ifdef TTA_FIXED_PRIO_EN
  // Rotation pinned at 0: lowest index always wins.
  assign ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
    end
  end

  assign ptr = rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      gv_r  <= 1'b0;
      gid_r <= '0;
    end else begin
      gv_r <= xfer;
      if (xfer) begin
        q_r[tidx] <= ~q_r[tidx];
        gid_r     <= win;
      end
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.q           = q_r;
  assign bus.grant_valid = gv_r;
  assign bus.grant_id    = gid_r;

endmodule
